// File: rtl/conv_pkg.sv
// Shared defaults and FSM encoding for the convolution window address generator.
package conv_pkg;

  localparam int CONV_IMG_W  = 32;
  localparam int CONV_IMG_H  = 32;
  localparam int CONV_K      = 3;
  localparam int CONV_STRIDE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up counter with enable, synchronous clear and a terminal-count flag.
module wrap_counter #(
  parameter int MOD = 4,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(MOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Streams row-major pixel addresses for every KxK window of an image, window by window,
// under a valid/ready handshake; window bases are tracked with adders only.
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = CONV_IMG_W,
  parameter int IMG_H  = CONV_IMG_H,
  parameter int K      = CONV_K,
  parameter int STRIDE = CONV_STRIDE,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              win_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] V_STEP   = ADDR_W'(STRIDE * IMG_W);

  if (K < 1 || K > IMG_W || K > IMG_H || STRIDE < 1 ||
      ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_bad_params
    $error("conv_window_addr_gen: illegal parameter combination");
  end

  conv_state_e state, state_n;

  logic [KW-1:0]  kx_cnt, ky_cnt, kx_n, ky_n;
  logic [OXW-1:0] ox_cnt;
  logic [OYW-1:0] oy_cnt;
  logic           kx_last, ky_last, ox_last, oy_last;
  logic           adv, kill, frame_end, win_last_n;

  // win_row: first pixel of the current window row; win_base: current window origin;
  // row_ptr: first pixel of the current kernel row inside the window.
  logic [ADDR_W-1:0] win_row, win_base, row_ptr;
  logic [ADDR_W-1:0] win_row_n, win_base_n, row_ptr_n, addr_n;

  assign adv       = (state == ST_RUN) && addr_valid && addr_ready && !abort;
  assign kill      = (state != ST_RUN) || abort;
  assign frame_end = (kx_cnt == KW'(K - 1)) && (ky_cnt == KW'(K - 1)) &&
                     (ox_cnt == OXW'(OUT_W - 1)) && (oy_cnt == OYW'(OUT_H - 1));

  wrap_counter #(.MOD(K), .W(KW)) u_kx (
    .clk(clk), .reset(reset), .en(adv), .clr(kill), .count(kx_cnt), .last(kx_last)
  );
  wrap_counter #(.MOD(K), .W(KW)) u_ky (
    .clk(clk), .reset(reset), .en(adv && kx_last), .clr(kill), .count(ky_cnt), .last(ky_last)
  );
  wrap_counter #(.MOD(OUT_W), .W(OXW)) u_ox (
    .clk(clk), .reset(reset), .en(adv && kx_last && ky_last), .clr(kill),
    .count(ox_cnt), .last(ox_last)
  );
  wrap_counter #(.MOD(OUT_H), .W(OYW)) u_oy (
    .clk(clk), .reset(reset), .en(adv && kx_last && ky_last && ox_last), .clr(kill),
    .count(oy_cnt), .last(oy_last)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_RUN;
      ST_RUN: begin
        if (abort)                  state_n = ST_IDLE;
        else if (adv && frame_end)  state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    win_row_n  = win_row;
    win_base_n = win_base;
    row_ptr_n  = row_ptr;
    addr_n     = pixel_addr;
    kx_n       = kx_cnt;
    ky_n       = ky_cnt;
    if (adv) begin
      kx_n = kx_last ? '0 : kx_cnt + 1'b1;
      if (kx_last) ky_n = ky_last ? '0 : ky_cnt + 1'b1;
      if (!kx_last) begin
        addr_n = pixel_addr + 1'b1;
      end else if (!ky_last) begin
        row_ptr_n = row_ptr + ROW_STEP;
        addr_n    = row_ptr_n;
      end else if (!ox_last) begin
        win_base_n = win_base + H_STEP;
        row_ptr_n  = win_base_n;
        addr_n     = win_base_n;
      end else if (!oy_last) begin
        win_row_n  = win_row + V_STEP;
        win_base_n = win_row_n;
        row_ptr_n  = win_row_n;
        addr_n     = win_row_n;
      end
    end
    // Leaving RUN (frame end or abort) parks the datapath at zero for the next frame.
    if (state_n != ST_RUN) begin
      win_row_n  = '0;
      win_base_n = '0;
      row_ptr_n  = '0;
      addr_n     = '0;
    end
    win_last_n = (state_n == ST_RUN) && (kx_n == KW'(K - 1)) && (ky_n == KW'(K - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      win_last   <= 1'b0;
      pixel_addr <= '0;
      win_row    <= '0;
      win_base   <= '0;
      row_ptr    <= '0;
    end else begin
      addr_valid <= (state_n == ST_RUN);
      busy       <= (state_n == ST_RUN);
      frame_done <= (state_n == ST_DONE);
      win_last   <= win_last_n;
      pixel_addr <= addr_n;
      win_row    <= win_row_n;
      win_base   <= win_base_n;
      row_ptr    <= row_ptr_n;
    end
  end

endmodule
